// File: rtl/ip_codma_pkg.sv
// Shared types and helpers for the co-DMA memory arbiter.
//   codma_state_e   : arbiter FSM state encoding
//   SIZE_*          : transfer size codes (beats = 2^size)
//   beats_from_size : converts a size code to its beat count
package ip_codma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } codma_state_e;

    localparam logic [3:0] SIZE_1DW = 4'd0;
    localparam logic [3:0] SIZE_2DW = 4'd1;
    localparam logic [3:0] SIZE_4DW = 4'd2;
    localparam logic [3:0] SIZE_8DW = 4'd3;

    function automatic int unsigned beats_from_size(input logic [3:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/ip_codma_rr_arbiter.sv
// Combinational round-robin picker.
//   req         in  : request vector, one bit per master
//   last_winner in  : index of the most recently served master
//   winner      out : first requester found searching from last_winner+1 (mod N)
//   valid       out : at least one request is present
module ip_codma_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                           req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   last_winner,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   winner,
    output logic                                   valid
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    int cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last_winner) + i) % N;
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ip_codma_mem_arbiter.sv
// Multi-master to single-slave memory arbiter for the co-DMA engine.
// Round-robin arbitration, one outstanding transaction at a time.
//   clock, reset_n               : clock / async active-low reset
//   m_read, m_write, m_addr,
//   m_size                       : per-master address-phase request
//   m_grant                      : one-hot end of address phase
//   m_read_data, m_read_valid    : broadcast read data, per-master strobe
//   m_write_data, m_write_valid  : per-master write data
//   m_error                      : per-master error strobe
//   s_*                          : single slave port
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate; register winner; illegal request goes to ERR
// ADDR  | winner's request on the slave, waiting for s_grant
// DATA  | beats moving; beat counter counts down to terminal count 1
// ERR   | one-cycle grant+error to winner, no slave request issued
module ip_codma_mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int MAX_BURST_LOG2 = 2
) (
    input  logic                                  clock,
    input  logic                                  reset_n,

    input  logic [NUM_MASTERS-1:0]                m_read,
    input  logic [NUM_MASTERS-1:0]                m_write,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]    m_addr,
    input  logic [NUM_MASTERS-1:0][3:0]           m_size,
    output logic [NUM_MASTERS-1:0]                m_grant,
    output logic [DATA_W-1:0]                     m_read_data,
    output logic [NUM_MASTERS-1:0]                m_read_valid,
    output logic [NUM_MASTERS-1:0]                m_error,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_write_data,
    input  logic [NUM_MASTERS-1:0]                m_write_valid,

    output logic                                  s_read,
    output logic                                  s_write,
    output logic [ADDR_W-1:0]                     s_addr,
    output logic [3:0]                            s_size,
    input  logic                                  s_grant,
    input  logic [DATA_W-1:0]                     s_read_data,
    input  logic                                  s_read_valid,
    output logic [DATA_W-1:0]                     s_write_data,
    output logic                                  s_write_valid,
    input  logic                                  s_error
);
    import ip_codma_pkg::*;

    localparam int         IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int         CNT_W    = MAX_BURST_LOG2 + 1;
    localparam logic [3:0] MAX_SIZE = 4'(MAX_BURST_LOG2);

    codma_state_e     state;
    codma_state_e     state_nxt;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] arb_winner;
    logic             arb_valid;
    logic [CNT_W-1:0] beat_cnt;
    logic             req_illegal;
    logic             beat;
    logic             last_beat;
    logic             load_cnt;
    logic             dec_cnt;
    logic             txn_done;

    ip_codma_rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr_arbiter (
        .req         (m_read | m_write),
        .last_winner (last_winner),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

    assign req_illegal = (m_size[arb_winner] > MAX_SIZE) ||
                         (m_read[arb_winner] && m_write[arb_winner]);
    assign beat        = s_read_valid | s_write_valid;
    assign last_beat   = beat && (beat_cnt == CNT_W'(1));
    // s_error takes priority over a grant or beat in the same cycle.
    assign load_cnt    = (state == ST_ADDR) && s_grant && !s_error;
    assign dec_cnt     = (state == ST_DATA) && beat && !s_error;
    // Any return to IDLE (done, abort or illegal) hands priority onward.
    assign txn_done    = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            winner      <= '0;
            last_winner <= IDX_W'(NUM_MASTERS - 1);
            beat_cnt    <= '0;
        end else begin
            if ((state == ST_IDLE) && arb_valid) begin
                winner <= arb_winner;
            end
            if (txn_done) begin
                last_winner <= winner;
                beat_cnt    <= '0;
            end else if (load_cnt) begin
                beat_cnt <= CNT_W'(beats_from_size(m_size[winner]));
            end else if (dec_cnt) begin
                beat_cnt <= beat_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = req_illegal ? ST_ERR : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_error) begin
                    state_nxt = ST_IDLE;
                end else if (s_grant) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_error || last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_grant       = '0;
        m_read_data   = '0;
        m_read_valid  = '0;
        m_error       = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_addr        = '0;
        s_size        = '0;
        s_write_data  = '0;
        s_write_valid = 1'b0;
        case (state)
            ST_ADDR: begin
                s_read          = m_read[winner];
                s_write         = m_write[winner];
                s_addr          = m_addr[winner];
                s_size          = m_size[winner];
                m_grant[winner] = s_grant;
                m_error[winner] = s_error;
            end
            ST_DATA: begin
                s_write_data         = m_write_data[winner];
                s_write_valid        = m_write_valid[winner];
                m_read_data          = s_read_data;
                m_read_valid[winner] = s_read_valid;
                m_error[winner]      = s_error;
            end
            ST_ERR: begin
                m_grant[winner] = 1'b1;
                m_error[winner] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ip_codma_mem_arbiter.sv
// Directed self-checking bench for ip_codma_mem_arbiter (2 masters).
module tb_ip_codma_mem_arbiter;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [1:0]        m_read, m_write, m_grant, m_read_valid, m_error, m_write_valid;
    logic [1:0][31:0]  m_addr;
    logic [1:0][3:0]   m_size;
    logic [1:0][63:0]  m_write_data;
    logic [63:0]       m_read_data;
    logic              s_read, s_write, s_grant, s_read_valid, s_write_valid, s_error;
    logic [31:0]       s_addr;
    logic [3:0]        s_size;
    logic [63:0]       s_read_data, s_write_data;

    int n_checks;
    int n_errors;

    ip_codma_mem_arbiter #(
        .NUM_MASTERS    (2),
        .ADDR_W         (32),
        .DATA_W         (64),
        .MAX_BURST_LOG2 (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_addr        (m_addr),
        .m_size        (m_size),
        .m_grant       (m_grant),
        .m_read_data   (m_read_data),
        .m_read_valid  (m_read_valid),
        .m_error       (m_error),
        .m_write_data  (m_write_data),
        .m_write_valid (m_write_valid),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_addr        (s_addr),
        .s_size        (s_size),
        .s_grant       (s_grant),
        .s_read_data   (s_read_data),
        .s_read_valid  (s_read_valid),
        .s_write_data  (s_write_data),
        .s_write_valid (s_write_valid),
        .s_error       (s_error)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point is 1 time unit after the rising edge; sampling 2 units later.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Single-master read from IDLE; grant after gnt_wait ADDR cycles.
    task automatic run_read(input int m, input logic [31:0] addr, input logic [3:0] size,
                            input int gnt_wait);
        logic [1:0] onehot;
        int nbeats;
        onehot    = 2'b01 << m;
        nbeats    = 1 << size;
        m_read[m] = 1'b1;
        m_addr[m] = addr;
        m_size[m] = size;
        next_cycle();
        for (int k = 0; k < gnt_wait; k++) begin
            settle();
            check_val("rd_s_read_addr_phase", {63'd0, s_read}, 64'd1);
            check_val("rd_no_grant_early", {62'd0, m_grant}, 64'd0);
            next_cycle();
        end
        s_grant = 1'b1;
        settle();
        check_val("rd_s_addr", {32'd0, s_addr}, {32'd0, addr});
        check_val("rd_s_size", {60'd0, s_size}, {60'd0, size});
        check_val("rd_grant", {62'd0, m_grant}, {62'd0, onehot});
        next_cycle();
        s_grant   = 1'b0;
        m_read[m] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_read_valid = 1'b1;
            s_read_data  = 64'hD000_0000_0000_0000 + 64'(b);
            settle();
            check_val("rd_beat_valid", {62'd0, m_read_valid}, {62'd0, onehot});
            check_val("rd_beat_data", m_read_data, 64'hD000_0000_0000_0000 + 64'(b));
            check_val("rd_s_read_in_data", {63'd0, s_read}, 64'd0);
            next_cycle();
        end
        // Back in IDLE: a stray slave strobe must not reach the master.
        settle();
        check_val("rd_idle_valid", {62'd0, m_read_valid}, 64'd0);
        check_val("rd_idle_s_read", {63'd0, s_read}, 64'd0);
        s_read_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        m_read        = '0;
        m_write       = '0;
        m_addr        = '0;
        m_size        = '0;
        m_write_data  = '0;
        m_write_valid = '0;
        s_grant       = 1'b0;
        s_read_data   = '0;
        s_read_valid  = 1'b0;
        s_error       = 1'b0;

        // Reset state, with requests and slave strobes active.
        repeat (2) next_cycle();
        m_read[0]    = 1'b1;
        s_read_valid = 1'b1;
        s_read_data  = 64'hFFFF;
        settle();
        check_val("rst_grant", {62'd0, m_grant}, 64'd0);
        check_val("rst_error", {62'd0, m_error}, 64'd0);
        check_val("rst_read_valid", {62'd0, m_read_valid}, 64'd0);
        check_val("rst_read_data", m_read_data, 64'd0);
        check_val("rst_s_read", {63'd0, s_read}, 64'd0);
        check_val("rst_s_addr", {32'd0, s_addr}, 64'd0);
        check_val("rst_s_write_valid", {63'd0, s_write_valid}, 64'd0);
        next_cycle();
        m_read       = '0;
        s_read_valid = 1'b0;
        s_read_data  = '0;
        reset_n      = 1'b1;

        // Single 4-beat read from m0, grant after two waiting cycles.
        run_read(0, 32'h1000, 4'd2, 2);

        // Contention from fresh reset: 0,1,0,1.
        reset_n = 1'b0;
        next_cycle();
        reset_n   = 1'b1;
        m_read    = 2'b11;
        m_addr[0] = 32'h2000;
        m_addr[1] = 32'h3000;
        m_size    = '0;
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            s_grant = 1'b1;
            settle();
            check_val("cont_grant", {62'd0, m_grant}, (t % 2 == 0) ? 64'd1 : 64'd2);
            check_val("cont_addr", {32'd0, s_addr}, (t % 2 == 0) ? 64'h2000 : 64'h3000);
            next_cycle();
            s_grant      = 1'b0;
            s_read_valid = 1'b1;
            settle();
            check_val("cont_valid", {62'd0, m_read_valid}, (t % 2 == 0) ? 64'd1 : 64'd2);
            next_cycle();
            s_read_valid = 1'b0;
        end
        m_read = '0;

        // Two-beat write from m1 with a gap cycle between beats.
        m_write[1] = 1'b1;
        m_addr[1]  = 32'h4000;
        m_size[1]  = 4'd1;
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("wr_s_write", {63'd0, s_write}, 64'd1);
        check_val("wr_s_read", {63'd0, s_read}, 64'd0);
        check_val("wr_s_size", {60'd0, s_size}, 64'd1);
        check_val("wr_grant", {62'd0, m_grant}, 64'd2);
        next_cycle();
        s_grant          = 1'b0;
        m_write[1]       = 1'b0;
        m_write_valid[1] = 1'b1;
        m_write_data[1]  = 64'hA5A5_A5A5_A5A5_A5A5;
        settle();
        check_val("wr_beat0_valid", {63'd0, s_write_valid}, 64'd1);
        check_val("wr_beat0_data", s_write_data, 64'hA5A5_A5A5_A5A5_A5A5);
        check_val("wr_s_write_in_data", {63'd0, s_write}, 64'd0);
        next_cycle();
        m_write_valid[1] = 1'b0;
        settle();
        check_val("wr_gap_valid", {63'd0, s_write_valid}, 64'd0);
        next_cycle();
        m_write_valid[1] = 1'b1;
        m_write_data[1]  = 64'h5A5A_5A5A_5A5A_5A5A;
        settle();
        check_val("wr_beat1_valid", {63'd0, s_write_valid}, 64'd1);
        check_val("wr_beat1_data", s_write_data, 64'h5A5A_5A5A_5A5A_5A5A);
        next_cycle();
        settle();
        check_val("wr_no_third_beat", {63'd0, s_write_valid}, 64'd0);
        check_val("wr_idle_data", s_write_data, 64'd0);
        m_write_valid = '0;

        // Slave error on the second beat of a 4-beat read.
        m_read[0] = 1'b1;
        m_addr[0] = 32'h5000;
        m_size[0] = 4'd2;
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("err_grant", {62'd0, m_grant}, 64'd1);
        next_cycle();
        s_grant      = 1'b0;
        m_read[0]    = 1'b0;
        s_read_valid = 1'b1;
        s_read_data  = 64'h11;
        settle();
        check_val("err_beat0_valid", {62'd0, m_read_valid}, 64'd1);
        next_cycle();
        s_read_valid = 1'b0;
        s_error      = 1'b1;
        settle();
        check_val("err_m_error", {62'd0, m_error}, 64'd1);
        check_val("err_no_valid", {62'd0, m_read_valid}, 64'd0);
        next_cycle();
        s_error      = 1'b0;
        s_read_valid = 1'b1;
        settle();
        check_val("err_after_valid", {62'd0, m_read_valid}, 64'd0);
        check_val("err_after_error", {62'd0, m_error}, 64'd0);
        check_val("err_after_s_read", {63'd0, s_read}, 64'd0);
        next_cycle();
        s_read_valid = 1'b0;

        // Illegal size from m0: ERR with no slave request.
        m_read[0] = 1'b1;
        m_size[0] = 4'd5;
        next_cycle();
        settle();
        check_val("ill_size_s_read", {63'd0, s_read}, 64'd0);
        check_val("ill_size_grant", {62'd0, m_grant}, 64'd1);
        check_val("ill_size_error", {62'd0, m_error}, 64'd1);
        next_cycle();
        m_read[0] = 1'b0;
        m_size[0] = 4'd0;
        settle();
        check_val("ill_size_one_cycle", {62'd0, m_grant | m_error}, 64'd0);

        // Illegal read+write from m1.
        m_read[1]  = 1'b1;
        m_write[1] = 1'b1;
        m_size[1]  = 4'd0;
        next_cycle();
        settle();
        check_val("ill_rw_s_rw", {62'd0, s_read, s_write}, 64'd0);
        check_val("ill_rw_grant", {62'd0, m_grant}, 64'd2);
        check_val("ill_rw_error", {62'd0, m_error}, 64'd2);
        next_cycle();
        m_read[1]  = 1'b0;
        m_write[1] = 1'b0;
        settle();
        check_val("ill_rw_one_cycle", {62'd0, m_grant | m_error}, 64'd0);

        // m0 completes so m1 would be next; then reset during m1's burst.
        m_read[0] = 1'b1;
        m_addr[0] = 32'h6000;
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("pre_rst_grant_m0", {62'd0, m_grant}, 64'd1);
        next_cycle();
        s_grant      = 1'b0;
        m_read[0]    = 1'b0;
        s_read_valid = 1'b1;
        next_cycle();
        s_read_valid = 1'b0;
        m_read[1]    = 1'b1;
        m_addr[1]    = 32'h7000;
        m_size[1]    = 4'd2;
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("pre_rst_grant_m1", {62'd0, m_grant}, 64'd2);
        next_cycle();
        s_grant      = 1'b0;
        m_read[1]    = 1'b0;
        s_read_valid = 1'b1;
        s_read_data  = 64'h77;
        settle();
        check_val("pre_rst_valid_m1", {62'd0, m_read_valid}, 64'd2);
        reset_n = 1'b0;
        s_grant = 1'b1;
        settle();
        check_val("mid_rst_valid", {62'd0, m_read_valid}, 64'd0);
        check_val("mid_rst_data", m_read_data, 64'd0);
        check_val("mid_rst_grant", {62'd0, m_grant}, 64'd0);
        next_cycle();
        s_grant      = 1'b0;
        s_read_valid = 1'b0;
        m_read       = 2'b11;
        m_addr[0]    = 32'h8000;
        m_addr[1]    = 32'h9000;
        m_size       = '0;
        reset_n      = 1'b1;
        settle();
        check_val("post_rst_idle", {63'd0, s_read}, 64'd0);
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("post_rst_m0_first", {62'd0, m_grant}, 64'd1);
        check_val("post_rst_addr", {32'd0, s_addr}, 64'h8000);
        next_cycle();
        s_grant      = 1'b0;
        m_read[0]    = 1'b0;
        s_read_valid = 1'b1;
        settle();
        check_val("post_rst_valid", {62'd0, m_read_valid}, 64'd1);
        next_cycle();
        s_read_valid = 1'b0;
        next_cycle();
        s_grant = 1'b1;
        settle();
        check_val("post_rst_m1_next", {62'd0, m_grant}, 64'd2);
        next_cycle();
        s_grant   = 1'b0;
        m_read[1] = 1'b0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_codma_mem_arbiter.md
IP_CODMA_MEM_ARBITER -- requirements
Module: ip_codma_mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_MASTERS, 2, requesting channels (2..8); ADDR_W, 32, address width; DATA_W, 64, data width; MAX_BURST_LOG2, 2, largest legal size code.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 m_read / m_write  in  NUM_MASTERS  per-master address-phase request.
REQ-005 m_addr  in  NUM_MASTERS x ADDR_W  per-master address.
REQ-006 m_size  in  NUM_MASTERS x 4  per-master size code; beats = 2^size.
REQ-007 m_grant  out  NUM_MASTERS  one-hot address-phase end.
REQ-008 m_read_data  out  DATA_W  broadcast read data.
REQ-009 m_read_valid / m_error  out  NUM_MASTERS  per-master read strobe, error strobe.
REQ-010 m_write_data  in  NUM_MASTERS x DATA_W; m_write_valid  in  NUM_MASTERS.
REQ-011 s_read, s_write  out  1; s_addr  out  ADDR_W; s_size  out  4; s_grant  in  1.
REQ-012 s_read_data  in  DATA_W; s_read_valid  in  1; s_write_data  out  DATA_W; s_write_valid  out  1; s_error  in  1.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, DATA, ERR.
REQ-014 IDLE: a master requests if m_read|m_write; winner SHALL be first requester searching from last_winner+1 modulo NUM_MASTERS; winner index registered; next state ADDR (or ERR per REQ-019).
REQ-015 ADDR: s_read/s_write/s_addr/s_size SHALL equal the winner's inputs; m_grant[winner] = s_grant combinationally; on s_grant load beat counter with 2^size, go DATA.
REQ-016 DATA: s_write_data/s_write_valid from winner; m_read_valid[winner] = s_read_valid; all other m_read_valid bits 0; counter decrements on each s_read_valid or s_write_valid beat.
REQ-017 DATA exit: on the beat taking counter 1->0, go IDLE and set last_winner = winner.
REQ-018 s_error in ADDR or DATA SHALL drive m_error[winner] that cycle, abort the transaction, go IDLE, update last_winner.
REQ-019 Illegal request (size > MAX_BURST_LOG2, or m_read and m_write both high) SHALL go to ERR without any slave request; ERR asserts m_grant[winner] and m_error[winner] for exactly one cycle, then IDLE.
REQ-020 Latency: request sampled in IDLE at cycle n SHALL appear on s_read/s_write at cycle n+1; no idle cycle required between back-to-back transactions other than the IDLE cycle itself.
REQ-021 Outside ADDR, s_read/s_write SHALL be 0; outside DATA, s_write_valid and all m_read_valid SHALL be 0; non-winners never see m_grant or m_error.
REQ-022 Masters SHALL hold request, address and size stable until m_grant; arbiter does not buffer requests.
REQ-023 Beat counter width SHALL be MAX_BURST_LOG2+1 bits; no wrap permitted.

Reset
REQ-024 On reset_n low, state SHALL be IDLE, last_winner = NUM_MASTERS-1 (master 0 first), counter 0, all outputs 0, regardless of transaction in progress.
REQ-025 Reset deassertion mid-burst SHALL not complete the aborted burst; first post-reset request re-arbitrates.

Structure
REQ-026 Package ip_codma_pkg SHALL hold the state enum, size-code constants (SIZE_1DW=0, SIZE_2DW=1, SIZE_4DW=2, SIZE_8DW=3) and a beats-from-size function.
REQ-027 Round-robin selection SHALL be sub-module ip_codma_rr_arbiter (request vector, last_winner in; winner index, valid out; combinational).

Verification
REQ-028 Single read: m0 read 0x1000 size 2, slave grants after 2 cycles -> s_read at n+1, four m_read_valid[0] pulses, IDLE after 4th beat.
REQ-029 Contention: m0 and m1 request in same cycle after reset -> m0 granted first, then m1; repeated requests alternate 0,1,0,1.
REQ-030 Write burst size 1 from m1 with gap between write_valid beats -> exactly two s_write_valid, data 0xA5A5.., 0x5A5A.. in order.
REQ-031 s_error on 2nd beat of 4-beat read -> m_error[winner] one cycle, return to IDLE, no further m_read_valid.
REQ-032 m0 size 5 with MAX_BURST_LOG2=2 -> no s_read, m_grant[0]&m_error[0] one cycle.
REQ-033 reset_n low during DATA -> all outputs 0 same cycle; after release m0 wins first.
